// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an 8-bit FIFO read port and sends each one as
// a UART frame (start, DATA_W data bits LSB first, optional even parity, stop).
// Optional feature macro: FIFO_UART_TX_PARITY_EN adds the even-parity bit.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              fifo_Empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  input  logic              tx_en,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd6
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_baud;
  logic [BIT_W-1:0]    r_bit;
  logic                r_tx;
  logic                r_rd_en;
  logic                r_busy;
  logic                r_byte_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                r_parity;
  logic                w_parity_nxt;
`endif

  state_t              w_state_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]    w_baud_nxt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic                w_tx_nxt;
  logic                w_rd_en_nxt;
  logic                w_busy_nxt;
  logic                w_byte_done_nxt;
  logic                w_baud_tc;
  logic                w_last_bit;

  assign w_baud_tc  = (r_baud == CNT_W'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_bit == BIT_W'(DATA_W - 1));

  // Next-state, datapath and next registered-output values
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_baud_nxt      = r_baud;
    w_bit_nxt       = r_bit;
    w_byte_done_nxt = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    w_parity_nxt    = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        if (tx_en && !fifo_Empty) w_state_nxt = S_POP;
      end
      S_POP: begin
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_shift_nxt = rd_data;
        w_bit_nxt   = '0;
        w_baud_nxt  = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        w_parity_nxt = ^rd_data;
`endif
        w_state_nxt = S_START;
      end
      S_START: begin
        if (w_baud_tc) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_baud_tc) begin
          w_baud_nxt  = '0;
          w_shift_nxt = r_shift >> 1;
          if (w_last_bit) begin
            w_bit_nxt = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end else begin
          w_baud_nxt = r_baud + CNT_W'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_tc) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_baud_tc) begin
          w_baud_nxt      = '0;
          w_byte_done_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_baud_nxt = r_baud + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Line level follows the state being entered so tx is a pure register
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = w_parity_nxt;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase

    w_rd_en_nxt = (w_state_nxt == S_POP);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
  end

  // State, datapath and output registers; reset aborts any frame in flight
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_baud      <= '0;
      r_bit       <= '0;
      r_tx        <= 1'b1;
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_byte_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_baud      <= w_baud_nxt;
      r_bit       <= w_bit_nxt;
      r_tx        <= w_tx_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_busy      <= w_busy_nxt;
      r_byte_done <= w_byte_done_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity    <= w_parity_nxt;
`endif
    end
  end

  assign tx        = r_tx;
  assign rd_en     = r_rd_en;
  assign busy      = r_busy;
  assign byte_done = r_byte_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: FIFO responder + line-level UART monitor with a byte
// scoreboard; timing expectations come from the frame/latency rules.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FB  = DW + 3;
`else
  localparam int FB  = DW + 2;
`endif
  localparam int FRAME_CYC = FB * CPB;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          fifo_Empty = 1'b1;
  logic [DW-1:0] rd_data = '0;
  logic          rd_en;
  logic          tx_en = 1'b1;
  logic          tx;
  logic          busy;
  logic          byte_done;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .fifo_Empty(fifo_Empty),
    .rd_data   (rd_data),
    .rd_en     (rd_en),
    .tx_en     (tx_en),
    .tx        (tx),
    .busy      (busy),
    .byte_done (byte_done)
  );

  always #5 rd_clk = ~rd_clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int mon_pos = -1;
  int start_at = -1;
  int n_frames = 0;
  int n_pops = 0;
  logic rst_q = 1'b1;
  logic [FB-1:0] cur_frame = '1;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  function automatic logic [FB-1:0] mk_frame(input logic [DW-1:0] b);
    logic [FB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[i+1] = b[i];
`ifdef FIFO_UART_TX_PARITY_EN
    f[DW+1] = ^b;
`endif
    return f;
  endfunction

  function automatic void chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Remembers whether the DUT saw reset at the last rising edge
  always @(posedge rd_clk) rst_q <= rd_rst;

  // Monitor + scoreboard, then FIFO responder, then start predictor
  always @(negedge rd_clk) begin
    cyc++;
    if (rst_q) begin
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rd_en", rd_en, 1'b0);
      chk("rst_byte_done", byte_done, 1'b0);
      mon_pos  = -1;
      start_at = -1;
      exp_q.delete();
    end else begin
      chk("rd_en", rd_en, (start_at >= 0) && (cyc == start_at - 2));
      chk("byte_done", byte_done, mon_pos == FRAME_CYC);
      if (mon_pos < 0 && start_at >= 0 && cyc == start_at) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL frame_byte: got none expected a popped byte (cycle %0d)", cyc);
          cur_frame = '1;
        end else begin
          cur_frame = mk_frame(exp_q.pop_front());
        end
        mon_pos  = 0;
        start_at = -1;
      end
      if (mon_pos >= 0 && mon_pos < FRAME_CYC) begin
        chk($sformatf("tx_bit%0d", mon_pos / CPB), tx, cur_frame[mon_pos / CPB]);
        chk("busy_frame", busy, 1'b1);
        mon_pos++;
      end else if (mon_pos == FRAME_CYC) begin
        chk("tx_after_stop", tx, 1'b1);
        chk("busy_after_stop", busy, 1'b0);
        n_frames++;
        mon_pos = -1;
      end else begin
        chk("tx_idle", tx, 1'b1);
        chk("busy_idle", busy, start_at >= 0);
      end
    end

    if (rd_en === 1'b1) begin
      if (fifo_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL underflow: got rd_en=1 expected no pop of empty FIFO (cycle %0d)", cyc);
      end else begin
        rd_data = fifo_q.pop_front();
        exp_q.push_back(rd_data);
        n_pops++;
      end
    end
    fifo_Empty = (fifo_q.size() == 0);

    if (mon_pos < 0 && start_at < 0 && !rd_rst && tx_en && !fifo_Empty)
      start_at = cyc + 3;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (!(mon_pos < 0 && start_at < 0 && (fifo_q.size() == 0 || !tx_en)) && k < budget) begin
      tick(1);
      k++;
    end
    tick(2);
    chk_int({name, "_timeout"}, (k < budget) ? 1 : 0, 1);
  endtask

  task automatic wait_pos(input string name, input int pos, input int budget);
    int k;
    k = 0;
    while (mon_pos != pos && k < budget) begin
      tick(1);
      k++;
    end
    chk_int({name, "_timeout"}, (k < budget) ? 1 : 0, 1);
  endtask

  initial begin
    // Reset for three edges with data waiting and transmit enabled, then one byte
    fifo_q.push_back(8'hA5);
    tick(3);
    rd_rst = 1'b0;
    wait_idle("single", 400);

    // Back-to-back frames
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h3C);
    wait_idle("b2b", 600);

    // Empty FIFO with transmit enabled
    tick(100);

    // Drop tx_en mid-frame: frame completes, nothing else is popped
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'h77);
    wait_pos("txen_data", 2 * CPB, 200);
    tx_en = 1'b0;
    wait_idle("txen", 400);
    tick(20);
    chk_int("txen_fifo_left", fifo_q.size(), 1);
    tx_en = 1'b1;
    wait_idle("txen_resume", 400);

    // Reset during data bit 3, then the next byte goes out cleanly
    fifo_q.push_back(8'hC3);
    fifo_q.push_back(8'h5A);
    wait_pos("rst_mid_bit3", 4 * CPB + 1, 200);
    rd_rst = 1'b1;
    tick(1);
    rd_rst = 1'b0;
    wait_idle("rst_mid", 400);

    // Randomized traffic with tx_en toggling
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 60)) begin
        tick(1);
        if ($urandom_range(0, 9) == 0) tx_en = ~tx_en;
      end
      fifo_q.push_back(DW'($urandom));
    end
    tx_en = 1'b1;
    wait_idle("random", 5000);

    chk_int("frames_sent", n_frames, 31);
    chk_int("pops", n_pops, 32);
    chk_int("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected end of test (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
